// File: rtl/seq_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_stage_pkg
// Description : Shared types and helpers for the stage sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package seq_stage_pkg;

  // Sequencer states; IDLE must stay at encoding 0 so reset lands there
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LAUNCH = 3'd1,
    WAIT   = 3'd2,
    FIN    = 3'd3,
    ERR    = 3'd4,
    ABORT  = 3'd5
  } state_t;

  // Width of a stage index; a single-stage build still gets a 1-bit index
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/seq_next_sel.sv
`default_nettype none
// ============================================================================
// Module      : seq_next_sel
// Description : Lowest-set-bit finder. mode=0 searches the whole mask
//               ("first"), mode=1 searches only bits strictly above cur_idx
//               ("next"). idx is 0 when nothing is found.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_next_sel #(
  parameter int unsigned N  = 3,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  mask,
  input  logic [IW-1:0] cur_idx,
  input  logic          mode,
  output logic          found,
  output logic [IW-1:0] idx
);

  // Scan from the top down so the last hit written is the lowest eligible bit
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (mask[i] && (!mode || (i > int'(cur_idx)))) begin
        found = 1'b1;
        idx   = IW'(i);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/seq_stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : seq_stage_ctrl
// Description : Moore sequencer that launches enabled sub-units in index
//               order, waits for each done strobe, and reports completion,
//               per-stage timeout or abort with one-cycle pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_stage_ctrl
  import seq_stage_pkg::*;
#(
  parameter int unsigned NUM_STAGES     = 3,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned IDX_W          = idx_width(NUM_STAGES)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [NUM_STAGES-1:0] stage_en,
  input  logic [NUM_STAGES-1:0] done_in,
  output logic [NUM_STAGES-1:0] start_out,
  output logic                  busy,
  output logic [IDX_W-1:0]      cur_stage,
  output logic                  done,
  output logic                  error,
  output logic [IDX_W-1:0]      err_stage,
  output logic                  aborted
);

  localparam int unsigned         c_TW       = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam bit                  c_TMO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [c_TW-1:0]     c_TMO_LAST = c_TW'(TIMEOUT_CYCLES - 1);

  state_t                r_state, w_state_nxt;
  logic [IDX_W-1:0]      r_idx, w_idx_nxt;
  logic [c_TW-1:0]       r_timer, w_timer_nxt;
  logic [NUM_STAGES-1:0] r_mask, w_mask_nxt;
  logic [IDX_W-1:0]      r_err_stage, w_err_nxt;

  logic [NUM_STAGES-1:0] w_sel_mask;
  logic                  w_sel_mode;
  logic                  w_sel_found;
  logic [IDX_W-1:0]      w_sel_idx;

  // In IDLE the finder looks at the live enable mask (it becomes mask_q this
  // edge); afterwards it searches the captured mask above the current stage.
  assign w_sel_mask = (r_state == IDLE) ? stage_en : r_mask;
  assign w_sel_mode = (r_state != IDLE);

  seq_next_sel #(
    .N  (NUM_STAGES),
    .IW (IDX_W)
  ) u_next_sel (
    .mask    (w_sel_mask),
    .cur_idx (r_idx),
    .mode    (w_sel_mode),
    .found   (w_sel_found),
    .idx     (w_sel_idx)
  );

  // State, stage index, timer, mask and error index registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_timer     <= '0;
      r_mask      <= '0;
      r_err_stage <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_timer     <= w_timer_nxt;
      r_mask      <= w_mask_nxt;
      r_err_stage <= w_err_nxt;
    end
  end

  // Next-state logic; in WAIT abort beats done_in[idx], which beats timeout
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_timer_nxt = r_timer;
    w_mask_nxt  = r_mask;
    w_err_nxt   = r_err_stage;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_mask_nxt  = stage_en;
          w_err_nxt   = '0;
          w_idx_nxt   = w_sel_idx;
          w_state_nxt = w_sel_found ? LAUNCH : FIN;
        end
      end
      LAUNCH: begin
        w_timer_nxt = '0;
        w_state_nxt = abort ? ABORT : WAIT;
      end
      WAIT: begin
        if (abort) begin
          w_state_nxt = ABORT;
        end else if (done_in[r_idx]) begin
          if (w_sel_found) begin
            w_idx_nxt   = w_sel_idx;
            w_state_nxt = LAUNCH;
          end else begin
            w_state_nxt = FIN;
          end
        end else if (c_TMO_EN && (r_timer == c_TMO_LAST)) begin
          w_err_nxt   = r_idx;
          w_state_nxt = ERR;
        end else if (r_timer != '1) begin
          w_timer_nxt = r_timer + 1'b1;
        end
      end
      FIN, ERR, ABORT: w_state_nxt = IDLE;
      default:         w_state_nxt = IDLE;
    endcase
  end

  // Outputs decoded purely from registered state, index and error index
  assign start_out = (r_state == LAUNCH) ? (NUM_STAGES'(1) << r_idx) : '0;
  assign busy      = (r_state != IDLE);
  assign cur_stage = busy ? r_idx : '0;
  assign done      = (r_state == FIN);
  assign error     = (r_state == ERR);
  assign aborted   = (r_state == ABORT);
  assign err_stage = r_err_stage;

endmodule
`default_nettype wire

// File: doc/seq_stage_ctrl.md
Name: seq_stage_ctrl

Overview:
- Parametrised Moore sequencer that launches up to NUM_STAGES sub-units one after another and waits for each unit's done before starting the next.
- Adds a per-run stage-enable mask, a per-stage timeout with error reporting, and an abort input.
- Sits between a top-level control FSM (start/done handshake) and the processing sub-units (start pulse / done strobe per unit).

Parameters:
- NUM_STAGES, 3, number of sequenced sub-units. Legal range 1..16.
- TIMEOUT_CYCLES, 1024, maximum WAIT cycles per stage before error. 0 disables the timeout.
- IDX_W, $clog2(NUM_STAGES) (minimum 1), width of the stage index. Derived; do not override.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  request a run. Accepted only in IDLE.
- abort  in  1  cancel the run in progress.
- stage_en  in  NUM_STAGES  stage enable mask. Bit i enables stage i. Sampled when start is accepted.
- done_in  in  NUM_STAGES  per-stage completion strobe.
- start_out  out  NUM_STAGES  one-cycle start pulse to stage i.
- busy  out  1  high in every state except IDLE.
- cur_stage  out  IDX_W  index of the active stage.
- done  out  1  one-cycle pulse when the run completes.
- error  out  1  one-cycle pulse on timeout.
- err_stage  out  IDX_W  index of the stage that timed out.
- aborted  out  1  one-cycle pulse when an abort is taken.

Behaviour:
- Reset: clk and reset_n only; reset_n low forces state to IDLE asynchronously. All outputs, mask register, stage index, timer and err_stage clear to 0. Reset mid-run drops start_out at once; no done, error or aborted pulse is generated.
- Output decoding: every output is decoded from registered state, index and err_stage only. There is no combinational path from any input to any output.
- State IDLE:
  - If start=1, capture stage_en into mask_q and compute first = lowest set bit of mask_q.
  - If any bit is set, go to LAUNCH with idx=first. If the mask is all-zero, go to FIN.
  - abort in IDLE is ignored.
- State LAUNCH:
  - start_out[idx]=1 for exactly one cycle; clear the timer; go to WAIT.
  - abort in LAUNCH: the pulse still issues this cycle, then go to ABORT.
- State WAIT:
  - Priority, highest first: abort, then done_in[idx], then timeout.
  - abort: go to ABORT.
  - done_in[idx]: nxt = lowest set bit of mask_q above idx. If it exists, go to LAUNCH with idx=nxt; otherwise go to FIN.
  - timeout: TIMEOUT_CYCLES != 0 and timer == TIMEOUT_CYCLES-1. Latch err_stage=idx and go to ERR.
  - Otherwise increment the timer. The timer saturates and never wraps.
  - done_in bits other than idx are ignored in every state.
- States FIN, ERR, ABORT:
  - FIN: done=1 for one cycle, then IDLE.
  - ERR: error=1 for one cycle, then IDLE.
  - ABORT: aborted=1 for one cycle, then IDLE.
  - start is ignored in all three; it is accepted only once back in IDLE.
- Latency:
  - start seen in cycle 0 gives start_out in cycle 1.
  - done_in[idx] seen in cycle k gives the next start_out, or done, in cycle k+1.
  - Empty mask: done in cycle 1.
- busy and cur_stage: busy=1 in LAUNCH, WAIT, FIN, ERR and ABORT. cur_stage=idx whenever busy=1, else 0.
- Hold: err_stage holds its value until the next accepted start, which clears it to 0.
- Widths and encoding: the timer is $clog2(TIMEOUT_CYCLES+1) bits, minimum 1. State is a 3-bit enumeration.

Decomposition:
- Package seq_stage_pkg: state enum (IDLE, LAUNCH, WAIT, FIN, ERR, ABORT) and a function returning the IDX_W width.
- Sub-module seq_next_sel: combinational finder with inputs mask and cur_idx, a mode bit (first/next), and outputs found and idx. It is the lowest-set-bit priority encoder above cur_idx, or above -1 for "first".

Test Plan:
- Full run: NUM_STAGES=3, stage_en=3'b111, start in cycle 0, each done_in[i] asserted 5 cycles after start_out[i]. Required: start_out=001 at cycle 1, 010 at cycle 7, 100 at cycle 13, done at cycle 19; busy high from cycle 1 to 19.
- Skip and empty mask: stage_en=3'b101 gives start_out 001 then 100, never 010. stage_en=3'b000 gives done at cycle 1 with start_out never asserted.
- Timeout: TIMEOUT_CYCLES=8, stage 1 never completes. Required: error pulses 9 cycles after start_out[1], err_stage=1, no done; the next start clears err_stage.
- Precedence: done_in[idx] together with abort in WAIT gives aborted, not advance. done_in[idx] in the final timeout cycle gives advance, not error. Wrong-index done_in (done_in[2] while idx=0) is ignored.
- Reset and start handling: reset_n low mid-WAIT clears all outputs the same cycle, and a run works normally after release. start held high during a run causes no restart until after FIN.
